// File: rtl/spram_x32.sv
// Single-port 32-bit synchronous RAM with a Wishbone B4 pipelined slave port.
// One-cycle read latency, byte-lane writes, never stalls, never errors.
module spram_x32 #(
  parameter int unsigned size = 'h10000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] adr,
  input  logic [31:0] dat_m,
  output logic [31:0] dat_s,
  input  logic        cyc,
  input  logic        stb,
  input  logic        we,
  input  logic [3:0]  sel,
  output logic        stall,
  output logic        ack,
  output logic        err
);

  localparam int unsigned Depth = size / 4;
  localparam int unsigned AddrW = $clog2(size);
  localparam int unsigned IdxW  = (Depth > 1) ? $clog2(Depth) : 1;

  logic [31:0]     mem [Depth];
  logic [IdxW-1:0] idx;
  logic            req;
  logic            ack_q, ack_d;
  logic [31:0]     dat_q, dat_d;
  logic            adr_unused;

  // Address bits outside the word index are deliberately ignored so that
  // out-of-range addresses wrap modulo the memory size.
  generate
    if (Depth > 1) begin : g_idx
      assign idx = adr[AddrW-1:2];
    end else begin : g_idx_one
      assign idx = '0;
    end
  endgenerate

  assign adr_unused = ^adr;
  assign req        = cyc & stb;
  assign stall      = 1'b0;
  assign err        = 1'b0;
  assign ack        = ack_q;
  assign dat_s      = dat_q;

  always_comb begin
    ack_d = req;
    dat_d = dat_q;
    if (req && !we) begin
      dat_d = mem[idx];
    end
  end

  // mem shares the reset block only so that requests seen during reset are
  // dropped; its contents are never cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= ack_d;
      dat_q <= dat_d;
      if (req && we) begin
        for (int i = 0; i < 4; i++) begin
          if (sel[i]) begin
            mem[idx][8*i +: 8] <= dat_m[8*i +: 8];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_spram_x32.sv
// Directed self-checking bench for spram_x32: reads, byte-lane writes,
// address wrap, asynchronous reset mid-burst and cyc gating.
module tb_spram_x32;

  logic        clk;
  logic        rst;
  logic [31:0] adr;
  logic [31:0] dat_m;
  logic [31:0] dat_s;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic        stall;
  logic        ack;
  logic        err;

  int compared;
  int mismatched;

  spram_x32 #(.size('h10000)) dut (
    .clk   (clk),
    .rst   (rst),
    .adr   (adr),
    .dat_m (dat_m),
    .dat_s (dat_s),
    .cyc   (cyc),
    .stb   (stb),
    .we    (we),
    .sel   (sel),
    .stall (stall),
    .ack   (ack),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic c, input logic s, input logic w,
                               input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] bs);
    cyc   = c;
    stb   = s;
    we    = w;
    adr   = a;
    dat_m = d;
    sel   = bs;
  endtask

  // Advance one edge, then check ack/dat_s plus the tied-off stall/err.
  task automatic step(input string tag, input logic expAck, input logic [31:0] expDat);
    @(posedge clk);
    #1;
    checkOutput({tag, ".ack"}, {31'd0, ack}, {31'd0, expAck});
    checkOutput({tag, ".dat"}, dat_s, expDat);
    checkOutput({tag, ".stall"}, {31'd0, stall}, 32'd0);
    checkOutput({tag, ".err"}, {31'd0, err}, 32'd0);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    #1;
    checkOutput("reset.ack", {31'd0, ack}, 32'd0);
    checkOutput("reset.dat", dat_s, 32'd0);
    step("reset_hold", 1'b0, 32'h0);
    rst = 1'b0;

    $display("[TB] preload words 0 and 1");
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h0, 32'h00000013, 4'hF);
    step("pre0", 1'b1, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h4, 32'hDEADBEEF, 4'hF);
    step("pre1", 1'b1, 32'h0);

    $display("[TB] back-to-back reads");
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 4'hF);
    step("rd0", 1'b1, 32'h00000013);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h4, 32'h0, 4'hF);
    step("rd4", 1'b1, 32'hDEADBEEF);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    step("idle_hold", 1'b0, 32'hDEADBEEF);

    $display("[TB] full word write then read");
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h100, 32'h12345678, 4'hF);
    step("wr100", 1'b1, 32'hDEADBEEF);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 4'hF);
    step("rd100", 1'b1, 32'h12345678);

    $display("[TB] byte lanes");
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h100, 32'hAABBCCDD, 4'b0101);
    step("wr_lanes", 1'b1, 32'h12345678);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
    step("rd_lanes", 1'b1, 32'h12BB56DD);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h100, 32'hFFFFFFFF, 4'b0000);
    step("wr_sel0", 1'b1, 32'h12BB56DD);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 4'hF);
    step("rd_sel0", 1'b1, 32'h12BB56DD);

    $display("[TB] address wrap and unaligned read");
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h10004, 32'hCAFEF00D, 4'hF);
    step("wr_wrap", 1'b1, 32'h12BB56DD);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h4, 32'h0, 4'hF);
    step("rd_wrap", 1'b1, 32'hCAFEF00D);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h104, 32'h0BADC0DE, 4'hF);
    step("wr104", 1'b1, 32'hCAFEF00D);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h106, 32'h0, 4'hF);
    step("rd106", 1'b1, 32'h0BADC0DE);

    $display("[TB] reset mid-burst");
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 4'hF);
    step("burst0", 1'b1, 32'h12BB56DD);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rst_async.ack", {31'd0, ack}, 32'd0);
    checkOutput("rst_async.dat", dat_s, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h100, 32'hFFFFFFFF, 4'hF);
    step("rst_req", 1'b0, 32'h0);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    step("post_rst", 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 4'hF);
    step("rd_preserved", 1'b1, 32'h12BB56DD);

    $display("[TB] cyc gating");
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h100, 32'h00000000, 4'hF);
    for (int i = 0; i < 5; i++) begin
      step("cyc_low", 1'b0, 32'h12BB56DD);
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 4'hF);
    step("rd_gated", 1'b1, 32'h12BB56DD);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    step("final_idle", 1'b0, 32'h12BB56DD);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
